// File: rtl/cpu_pkg.sv
// Shared control-sequencer types: FSM state encoding, opcode constants, IR field positions.
// The optional MUL/DIV path is enabled by defining CTRL_MULDIV_EN.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
`ifdef CTRL_MULDIV_EN
        ST_T6,
`endif
        ST_HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    // Strobes that depend only on the state being entered (plus the stable IR class),
    // so they can be produced straight from flops.
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic z_low_in;
        logic z_high_in;
        logic z_low_out;
        logic z_high_out;
        logic hi_in;
        logic lo_in;
        logic halted;
    } strobes_t;

    function automatic logic is_muldiv_op(input logic [4:0] op);
`ifdef CTRL_MULDIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == 5'b11111) && (op == 5'b00000);
`endif
    endfunction

    function automatic logic is_alu_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR)
            || is_muldiv_op(op);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: handshake inputs, control strobes and register selects.
interface control_sequencer_if;

    logic        run;
    logic [31:0] ir;
    logic        mem_ready;

    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        ZLowIn;
    logic        ZHighIn;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;
    logic [4:0]  opcode;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        halted;

    modport master (
        input  run, ir, mem_ready,
        output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn,
               Zlowout, Zhighout, HIin, LOin, opcode, reg_in, reg_out, halted
    );

    modport slave (
        output run, ir, mem_ready,
        input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn,
               Zlowout, Zhighout, HIin, LOin, opcode, reg_in, reg_out, halted
    );

endinterface

// File: rtl/reg_select_decoder.sv
// 4-bit register index plus enable to a 16-bit one-hot register strobe vector.
module reg_select_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    for (genvar gi = 0; gi < 16; gi++) begin : g_sel
        assign onehot[gi] = en && (idx == 4'(gi));
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control FSM for a register-file/ALU datapath.
// Define CTRL_MULDIV_EN to add MUL/DIV with the extra HI/LO write-back state T6.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    state_t      state_q, state_d;
    strobes_t    strb_q, strb_d;
    logic [4:0]  op;
    logic        alu;
    logic        muldiv;
    logic        yin;
    logic        out_en;
    logic        in_en;
    logic [3:0]  out_idx;
    logic        unused_ir_bits;

    assign op             = bus.ir[IR_OP_MSB:IR_OP_LSB];
    assign alu            = is_alu_op(op);
    assign muldiv         = is_muldiv_op(op);
    assign unused_ir_bits = ^bus.ir[14:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (bus.mem_ready) state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (op == OP_HALT)  state_d = ST_HALT;
                else if (alu)       state_d = ST_T4;
                else                state_d = ST_T0;
            end
            ST_T4:   state_d = ST_T5;
`ifdef CTRL_MULDIV_EN
            ST_T5:   state_d = muldiv ? ST_T6 : ST_T0;
            ST_T6:   state_d = ST_T0;
`else
            ST_T5:   state_d = ST_T0;
`endif
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // IR is already stable on the T3->T4 and T4->T5 edges, so the MUL/DIV
    // qualification of the Z/HI/LO strobes can be registered with the state.
    always_comb begin
        strb_d = '0;
        case (state_d)
            ST_T0: begin
                strb_d.pc_out = 1'b1;
                strb_d.mar_in = 1'b1;
                strb_d.inc_pc = 1'b1;
            end
            ST_T1: begin
                strb_d.read   = 1'b1;
                strb_d.mdr_in = 1'b1;
            end
            ST_T2: begin
                strb_d.mdr_out = 1'b1;
                strb_d.ir_in   = 1'b1;
            end
            ST_T4: begin
                strb_d.z_low_in  = 1'b1;
                strb_d.z_high_in = muldiv;
            end
            ST_T5: begin
                strb_d.z_low_out = 1'b1;
                strb_d.lo_in     = muldiv;
            end
`ifdef CTRL_MULDIV_EN
            ST_T6: begin
                strb_d.z_high_out = 1'b1;
                strb_d.hi_in      = 1'b1;
            end
`endif
            ST_HALT: strb_d.halted = 1'b1;
            default: strb_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
        end
    end

    // IR only becomes valid on the edge entering T3, so T3 decode must stay combinational.
    assign yin     = (state_q == ST_T3) && alu;
    assign out_en  = yin || (state_q == ST_T4);
    assign out_idx = (state_q == ST_T4) ? bus.ir[IR_RC_MSB:IR_RC_LSB] : bus.ir[IR_RB_MSB:IR_RB_LSB];
    assign in_en   = (state_q == ST_T5) && !muldiv;

    reg_select_decoder u_out_dec (
        .idx    (out_idx),
        .en     (out_en),
        .onehot (bus.reg_out)
    );

    reg_select_decoder u_in_dec (
        .idx    (bus.ir[IR_RA_MSB:IR_RA_LSB]),
        .en     (in_en),
        .onehot (bus.reg_in)
    );

    assign bus.opcode   = (state_q == ST_T4) ? op : 5'b00000;
    assign bus.Yin      = yin;
    assign bus.PCout    = strb_q.pc_out;
    assign bus.MARin    = strb_q.mar_in;
    assign bus.IncPC    = strb_q.inc_pc;
    assign bus.Read     = strb_q.read;
    assign bus.MDRin    = strb_q.mdr_in;
    assign bus.MDRout   = strb_q.mdr_out;
    assign bus.IRin     = strb_q.ir_in;
    assign bus.ZLowIn   = strb_q.z_low_in;
    assign bus.ZHighIn  = strb_q.z_high_in;
    assign bus.Zlowout  = strb_q.z_low_out;
    assign bus.Zhighout = strb_q.z_high_out;
    assign bus.HIin     = strb_q.hi_in;
    assign bus.LOin     = strb_q.lo_in;
    assign bus.halted   = strb_q.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; expectations switch with CTRL_MULDIV_EN.
module tb_control_sequencer;

    logic clk;
    logic clear;
    int   checks;
    int   errors;
    logic mon_en;

    control_sequencer_if bus();

    control_sequencer u_dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: PCout MARin IncPC Read MDRin MDRout IRin Yin ZLowIn ZHighIn Zlowout Zhighout HIin LOin
    logic [13:0] ctrl;
    assign ctrl = {bus.PCout, bus.MARin, bus.IncPC, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
                   bus.Yin, bus.ZLowIn, bus.ZHighIn, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin};

    localparam logic [13:0] C_NONE = 14'h0000;
    localparam logic [13:0] C_T0   = 14'h3800;
    localparam logic [13:0] C_T1   = 14'h0600;
    localparam logic [13:0] C_T2   = 14'h0180;
    localparam logic [13:0] C_YIN  = 14'h0040;
    localparam logic [13:0] C_ZLI  = 14'h0020;
    localparam logic [13:0] C_ZHI  = 14'h0010;
    localparam logic [13:0] C_ZLO  = 14'h0008;
    localparam logic [13:0] C_ZHO  = 14'h0004;
    localparam logic [13:0] C_HI   = 14'h0002;
    localparam logic [13:0] C_LO   = 14'h0001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [13:0] c, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [4:0] op, input logic h);
        chk({tag, ".ctrl"},    32'(ctrl),        32'(c));
        chk({tag, ".reg_in"},  32'(bus.reg_in),  32'(rin));
        chk({tag, ".reg_out"}, 32'(bus.reg_out), 32'(rout));
        chk({tag, ".opcode"},  32'(bus.opcode),  32'(op));
        chk({tag, ".halted"},  32'(bus.halted),  32'(h));
        $display("step %-10s ctrl=%04h reg_in=%04h reg_out=%04h opcode=%05b halted=%0b",
                 tag, ctrl, bus.reg_in, bus.reg_out, bus.opcode, bus.halted);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants every cycle: one-hot-or-zero selects, no read/write overlap, single bus driver.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert ($onehot0(bus.reg_in) && $onehot0(bus.reg_out)
                    && !((|bus.reg_in) && (|bus.reg_out))
                    && ($countones({bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, |bus.reg_out}) <= 1))
            else begin
                errors++;
                $error("FAIL invariant: reg_in=%04h reg_out=%04h drivers=%05b required one-hot-or-zero, single driver",
                       bus.reg_in, bus.reg_out, {bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, |bus.reg_out});
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        mon_en        = 1'b0;
        clear         = 1'b1;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir        = 32'h0;

        tick();
        mon_en = 1'b1;
        expect_all("reset", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        clear = 1'b0;
        tick();
        expect_all("idle", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);

        // AND R4,R3,R7
        bus.ir        = 32'h2A1B8000;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;
        tick(); expect_all("and.T0", C_T0,  16'h0,    16'h0,    5'b0,     1'b0);
        tick(); expect_all("and.T1", C_T1,  16'h0,    16'h0,    5'b0,     1'b0);
        tick(); expect_all("and.T2", C_T2,  16'h0,    16'h0,    5'b0,     1'b0);
        tick(); expect_all("and.T3", C_YIN, 16'h0,    16'h0008, 5'b0,     1'b0);
        tick(); expect_all("and.T4", C_ZLI, 16'h0,    16'h0080, 5'b00101, 1'b0);
        tick(); expect_all("and.T5", C_ZLO, 16'h0010, 16'h0,    5'b0,     1'b0);
        tick(); expect_all("and.T0b", C_T0, 16'h0,    16'h0,    5'b0,     1'b0);

        // Memory stall: three not-ready samples in T1 give four Read/MDRin cycles
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); expect_all($sformatf("stall.T1.%0d", i), C_T1, 16'h0, 16'h0, 5'b0, 1'b0);
        end
        bus.mem_ready = 1'b1;
        tick(); expect_all("stall.T2", C_T2,  16'h0, 16'h0,    5'b0,     1'b0);
        tick(); expect_all("stall.T3", C_YIN, 16'h0, 16'h0008, 5'b0,     1'b0);
        tick(); expect_all("stall.T4", C_ZLI, 16'h0, 16'h0080, 5'b00101, 1'b0);

        // Clear mid-instruction
        clear = 1'b1;
        tick(); expect_all("clrT4", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        clear = 1'b0;

        // NOP with nonzero register fields
        bus.ir = {5'b11010, 4'd5, 4'd6, 4'd7, 15'h0};
        tick(); expect_all("nop.T0", C_T0,   16'h0, 16'h0, 5'b0, 1'b0);
        tick(); expect_all("nop.T1", C_T1,   16'h0, 16'h0, 5'b0, 1'b0);
        tick(); expect_all("nop.T2", C_T2,   16'h0, 16'h0, 5'b0, 1'b0);
        tick(); expect_all("nop.T3", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        tick(); expect_all("nop.T0b", C_T0,  16'h0, 16'h0, 5'b0, 1'b0);

        // MUL R2,R9,R12
        bus.ir = {5'b01111, 4'd2, 4'd9, 4'd12, 15'h0};
        tick(); expect_all("mul.T1", C_T1, 16'h0, 16'h0, 5'b0, 1'b0);
        tick(); expect_all("mul.T2", C_T2, 16'h0, 16'h0, 5'b0, 1'b0);
`ifdef CTRL_MULDIV_EN
        tick(); expect_all("mul.T3", C_YIN,         16'h0, 16'h0200, 5'b0,     1'b0);
        tick(); expect_all("mul.T4", C_ZLI | C_ZHI, 16'h0, 16'h1000, 5'b01111, 1'b0);
        tick(); expect_all("mul.T5", C_ZLO | C_LO,  16'h0, 16'h0,    5'b0,     1'b0);
        tick(); expect_all("mul.T6", C_ZHO | C_HI,  16'h0, 16'h0,    5'b0,     1'b0);
`else
        tick(); expect_all("mul.T3", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);
`endif
        tick(); expect_all("mul.T0b", C_T0, 16'h0, 16'h0, 5'b0, 1'b0);

        // HALT: sticky regardless of run, left only by clear
        bus.ir = {5'b11011, 27'h0};
        tick(); expect_all("halt.T1", C_T1,   16'h0, 16'h0, 5'b0, 1'b0);
        tick(); expect_all("halt.T2", C_T2,   16'h0, 16'h0, 5'b0, 1'b0);
        tick(); expect_all("halt.T3", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_all($sformatf("halt.%0d", i), C_NONE, 16'h0, 16'h0, 5'b0, 1'b1);
            bus.run = ~bus.run;
        end
        clear = 1'b1;
        tick(); expect_all("halt.clr", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);
        clear   = 1'b0;
        bus.run = 1'b0;
        tick(); expect_all("halt.idle", C_NONE, 16'h0, 16'h0, 5'b0, 1'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
